// File: rtl/clk_phase_ctrl.sv
// Quadrature clock generator with a glitch-free selectable phase output.
// Phase switches drain the old phase low, then wait for the new phase's low half.
module clk_phase_ctrl #(
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [CW-1:0] div_val,
   input  logic          sel_req,
   input  logic [1:0]    sel_phase,
   output logic          ph_0,
   output logic          ph_90,
   output logic          ph_180,
   output logic          ph_270,
   output logic          ph_out,
   output logic [1:0]    cur_phase,
   output logic          sel_ack,
   output logic          busy
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, ALIGN} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [CW-1:0] div_lat, div_nxt;
   logic [1:0]    q, q_nxt;
   logic [1:0]    target, tgt_nxt;
   logic [1:0]    cur_nxt;
   logic          ack_nxt, busy_nxt;
   logic          ph0_nxt, ph90_nxt, run_nxt;
   logic          cnt_wrap, cur_level, tgt_low_start;
   logic [1:0]    tgt_low_q;

   assign cnt_wrap      = (cnt == div_lat);
   // First cycle of the target's low half: ph_out then stays low a full half period.
   assign tgt_low_q     = target + 2'd2;
   assign tgt_low_start = (q == tgt_low_q) && (cnt == '0);

   always_comb begin
      cur_level = 1'b0;
      case (cur_phase)
         2'd0: cur_level = ph_0;
         2'd1: cur_level = ph_90;
         2'd2: cur_level = ph_180;
         2'd3: cur_level = ph_270;
         default: cur_level = 1'b0;
      endcase
   end

   always_comb begin
      // NOTE: every signal gets a default before the case so no path can infer a latch.
      state_nxt = state;
      cnt_nxt   = cnt;
      q_nxt     = q;
      div_nxt   = div_lat;
      tgt_nxt   = target;
      cur_nxt   = cur_phase;
      ack_nxt   = 1'b0;
      busy_nxt  = busy;

      if (!en) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
         q_nxt     = 2'd0;
         busy_nxt  = 1'b0;
      end else if (state == IDLE) begin
         state_nxt = RUN;
         cnt_nxt   = '0;
         q_nxt     = 2'd0;
         div_nxt   = div_val;
      end else begin
         cnt_nxt = cnt_wrap ? '0 : cnt + CW'(1);
         if (cnt_wrap) begin
            q_nxt = q + 2'd1;
            if (q == 2'd3) div_nxt = div_val;
         end
         case (state)
            RUN: begin
               if (busy) begin
                  if (target == cur_phase) begin
                     ack_nxt  = 1'b1;
                     busy_nxt = 1'b0;
                  end else begin
                     state_nxt = DRAIN;
                  end
               end else if (sel_req) begin
                  tgt_nxt  = sel_phase;
                  busy_nxt = 1'b1;
               end
            end
            DRAIN: begin
               if (!cur_level) state_nxt = ALIGN;
            end
            ALIGN: begin
               if (tgt_low_start) begin
                  state_nxt = RUN;
                  cur_nxt   = target;
                  ack_nxt   = 1'b1;
                  busy_nxt  = 1'b0;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end

      run_nxt  = (state_nxt != IDLE);
      ph0_nxt  = run_nxt && (q_nxt == 2'd0 || q_nxt == 2'd1);
      ph90_nxt = run_nxt && (q_nxt == 2'd1 || q_nxt == 2'd2);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         q         <= 2'd0;
         div_lat   <= '0;
         target    <= 2'd0;
         cur_phase <= 2'd0;
         sel_ack   <= 1'b0;
         busy      <= 1'b0;
         ph_0      <= 1'b0;
         ph_90     <= 1'b0;
         ph_180    <= 1'b0;
         ph_270    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         q         <= q_nxt;
         div_lat   <= div_nxt;
         target    <= tgt_nxt;
         cur_phase <= cur_nxt;
         sel_ack   <= ack_nxt;
         busy      <= busy_nxt;
         ph_0      <= ph0_nxt;
         ph_90     <= ph90_nxt;
         ph_180    <= run_nxt & ~ph0_nxt;
         ph_270    <= run_nxt & ~ph90_nxt;
      end
   end

   always_comb begin
      ph_out = 1'b0;
      if (state == RUN || state == DRAIN) ph_out = cur_level;
   end

endmodule
